// File: rtl/display_mux_n.sv
// N-digit time-multiplexed common-anode seven-segment driver with frame-latched
// shadows, leading-zero suppression, PWM dimming and an anti-ghost blank per slot.

module display_mux_n_lane #(
    parameter int NUM_DIGITS = 8,
    parameter int IDX        = 0
) (
    input  logic [NUM_DIGITS-1:0][3:0] nibs,
    input  logic                       en,
    input  logic                       dp,
    input  logic                       lz,
    input  logic                       sel,
    input  logic                       gate,
    output logic                       lit,
    output logic                       dp_lit
);
    logic upper_zero;
    logic lz_blank;

    // this digit and every more-significant one are zero
    assign upper_zero = (nibs >> (4 * IDX)) == '0;
    assign lz_blank   = lz && upper_zero && (IDX != 0);
    assign lit        = sel && en && !lz_blank && gate;
    assign dp_lit     = lit && dp;
endmodule

module display_mux_n #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              CA,
    output logic                    DP,
    output logic                    frame_tick
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PS_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] nib;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0]      en;
        logic                       lz;
        logic [BRIGHT_W-1:0]        bright;
    } shadow_t;

    shadow_t               sh;
    logic [PW-1:0]         prescaler;
    logic [SW-1:0]         slot;
    logic [BRIGHT_W-1:0]   pwm_cnt;
    logic                  ps_term;
    logic                  frame_wrap;
    logic                  pwm_on;
    logic                  gate;
    logic [NUM_DIGITS-1:0] lit;
    logic [NUM_DIGITS-1:0] dp_lit;
    logic [3:0]            cur_nib;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    assign ps_term    = prescaler == PS_LAST;
    assign frame_wrap = ps_term && (slot == SLOT_LAST);
    assign pwm_on     = (pwm_cnt < sh.bright) || (&sh.bright);
    // prescaler == 0 is the dark cycle that hides the anode/segment switch
    assign gate       = pwm_on && (prescaler != '0);
    assign cur_nib    = sh.nib[slot];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
        display_mux_n_lane #(
            .NUM_DIGITS(NUM_DIGITS),
            .IDX       (i)
        ) u_lane (
            .nibs  (sh.nib),
            .en    (sh.en[i]),
            .dp    (sh.dp[i]),
            .lz    (sh.lz),
            .sel   (slot == SW'(i)),
            .gate  (gate),
            .lit   (lit[i]),
            .dp_lit(dp_lit[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            slot       <= '0;
            pwm_cnt    <= '0;
            sh         <= '0;
            AN         <= '1;
            CA         <= 7'h7F;
            DP         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            prescaler <= ps_term ? '0 : prescaler + 1'b1;
            if (ps_term)
                slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
            // shadows only move at frame wrap so a frame never mixes old and new data
            if (frame_wrap)
                sh <= {digits, dp_in, digit_en, lz_suppress, brightness};
            pwm_cnt    <= pwm_cnt + 1'b1;
            AN         <= ~lit;
            CA         <= (|lit) ? seg_decode(cur_nib) : 7'h7F;
            DP         <= ~(|dp_lit);
            frame_tick <= frame_wrap;
        end
    end
endmodule
